grid_status_mem: RTL and testbench



---
 rtl/pb_cfg_pkg.sv | 19 +
 rtl/grid_dpram.sv | 26 ++
 rtl/grid_status_mem.sv | 159 +++++++++++++++
 tb/tb_grid_status_mem.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_cfg_pkg.sv
// Shared playboard configuration: cell status codes, grid command opcodes and widths.
package pb_cfg_pkg;

    localparam int GRID_ADDR_W = 8;
    localparam int SHIP_CNT_W  = 9;

    localparam logic [1:0] GRID_STATUS_EMPTY  = 2'd0;
    localparam logic [1:0] GRID_STATUS_MYSHIP = 2'd1;
    localparam logic [1:0] GRID_STATUS_MISS   = 2'd2;
    localparam logic [1:0] GRID_STATUS_HIT    = 2'd3;

    typedef enum logic [1:0] {
        OP_PLACE = 2'd0,
        OP_SHOOT = 2'd1,
        OP_CLEAR = 2'd2,
        OP_RSVD  = 2'd3
    } grid_op_t;

endpackage

// File: rtl/grid_dpram.sv
// Dual-port cell-status RAM: registered read-first reads on both ports, writes on port B only.
module grid_dpram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr_a,
    output logic [DATA_W-1:0] q_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic              we_b,
    input  logic [DATA_W-1:0] d_b,
    output logic [DATA_W-1:0] q_b
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // No reset on the array so it maps onto RAM primitives.
    always_ff @(posedge clk) begin
        q_a <= mem[addr_a];
        q_b <= mem[addr_b];
        if (we_b) begin
            mem[addr_b] <= d_b;
        end
    end

endmodule

// File: rtl/grid_status_mem.sv
// Per-board cell-status store: display read port plus a place/shoot/clear command port.
module grid_status_mem
    import pb_cfg_pkg::*;
#(
    parameter int GRID_COLS   = 10,
    parameter int GRID_ROWS   = 10,
    parameter int CLEAR_DEPTH = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [GRID_ADDR_W-1:0] rd_addr,
    output logic [1:0]             rd_data,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [GRID_ADDR_W-1:0] cmd_addr,
    output logic                   resp_valid,
    output logic [1:0]             resp_status,
    output logic                   resp_err,
    output logic [SHIP_CNT_W-1:0]  ship_cnt,
    output logic                   busy
);

    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_RD, ST_WR} state_t;

    localparam logic [GRID_ADDR_W-1:0] CLR_LAST = GRID_ADDR_W'(CLEAR_DEPTH - 1);
    localparam logic [4:0]             COLS_L   = 5'(GRID_COLS);
    localparam logic [4:0]             ROWS_L   = 5'(GRID_ROWS);

    state_t                 state;
    logic [GRID_ADDR_W-1:0] clr_ptr;
    grid_op_t               op_q;
    logic [GRID_ADDR_W-1:0] addr_q;
    logic                   force_empty;
    logic [1:0]             q_a;
    logic [1:0]             q_b;
    logic [GRID_ADDR_W-1:0] addr_b;
    logic                   we_b;
    logic [1:0]             d_b;
    logic                   on_grid;
    logic                   res_we;
    logic                   res_err;
    logic [1:0]             res_status;
    logic                   cnt_inc;
    logic                   cnt_dec;

    grid_dpram #(
        .ADDR_W (GRID_ADDR_W),
        .DATA_W (2)
    ) u_ram (
        .clk    (clk),
        .addr_a (rd_addr),
        .q_a    (q_a),
        .addr_b (addr_b),
        .we_b   (we_b),
        .d_b    (d_b),
        .q_b    (q_b)
    );

    // Forcing flag is registered alongside the read so both reach rd_data together.
    assign rd_data = force_empty ? GRID_STATUS_EMPTY : q_a;
    assign on_grid = ({1'b0, addr_q[7:4]} < COLS_L) && ({1'b0, addr_q[3:0]} < ROWS_L);

    always_comb begin
        res_we     = 1'b0;
        res_err    = 1'b1;
        res_status = GRID_STATUS_EMPTY;
        cnt_inc    = 1'b0;
        cnt_dec    = 1'b0;
        if (on_grid && op_q == OP_PLACE) begin
            res_status = q_b;
            if (q_b == GRID_STATUS_EMPTY) begin
                res_we     = 1'b1;
                res_err    = 1'b0;
                res_status = GRID_STATUS_MYSHIP;
                cnt_inc    = 1'b1;
            end
        end else if (on_grid && op_q == OP_SHOOT) begin
            res_status = q_b;
            if (q_b == GRID_STATUS_EMPTY) begin
                res_we     = 1'b1;
                res_err    = 1'b0;
                res_status = GRID_STATUS_MISS;
            end else if (q_b == GRID_STATUS_MYSHIP) begin
                res_we     = 1'b1;
                res_err    = 1'b0;
                res_status = GRID_STATUS_HIT;
                cnt_dec    = 1'b1;
            end
        end
    end

    always_comb begin
        addr_b = (state == ST_CLEAR) ? clr_ptr : addr_q;
        we_b   = (state == ST_CLEAR) || (state == ST_WR && res_we);
        d_b    = (state == ST_CLEAR) ? GRID_STATUS_EMPTY : res_status;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_CLEAR;
            clr_ptr     <= '0;
            op_q        <= OP_PLACE;
            addr_q      <= '0;
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
            resp_valid  <= 1'b0;
            resp_status <= GRID_STATUS_EMPTY;
            resp_err    <= 1'b0;
            ship_cnt    <= '0;
            force_empty <= 1'b1;
        end else begin
            resp_valid  <= 1'b0;
            force_empty <= (state == ST_CLEAR);
            case (state)
                ST_CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == CLR_LAST) begin
                        state     <= ST_IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (grid_op_t'(cmd_op) == OP_CLEAR) begin
                            state    <= ST_CLEAR;
                            clr_ptr  <= '0;
                            ship_cnt <= '0;
                            busy     <= 1'b1;
                        end else begin
                            op_q   <= grid_op_t'(cmd_op);
                            addr_q <= cmd_addr;
                            state  <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    state <= ST_WR;
                end
                ST_WR: begin
                    resp_valid  <= 1'b1;
                    resp_status <= res_status;
                    resp_err    <= res_err;
                    cmd_ready   <= 1'b1;
                    state       <= ST_IDLE;
                    if (cnt_inc) begin
                        ship_cnt <= ship_cnt + 1'b1;
                    end else if (cnt_dec) begin
                        ship_cnt <= ship_cnt - 1'b1;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_status_mem.sv
// Self-checking bench for grid_status_mem: directed scenarios plus random commands vs a cell-array model.
module tb_grid_status_mem;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rd_addr = '0;
    logic [1:0] rd_data;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [7:0] cmd_addr = '0;
    logic       resp_valid;
    logic [1:0] resp_status;
    logic       resp_err;
    logic [8:0] ship_cnt;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int resp_pulses = 0;

    logic [1:0] model [0:255];
    int         model_cnt;

    grid_status_mem #(
        .GRID_COLS   (10),
        .GRID_ROWS   (10),
        .CLEAR_DEPTH (256)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .resp_valid  (resp_valid),
        .resp_status (resp_status),
        .resp_err    (resp_err),
        .ship_cnt    (ship_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (resp_valid === 1'b1) resp_pulses++;

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model[i] = 2'd0;
        model_cnt = 0;
    endtask

    // Game rules on a plain array: 0 empty, 1 ship, 2 miss, 3 hit.
    task automatic model_cmd(input int op, input int addr, output logic [1:0] st, output logic er);
        int col;
        int row;
        col = addr / 16;
        row = addr % 16;
        st = 2'd0;
        er = 1'b1;
        if (op == 3 || col >= 10 || row >= 10) begin
            st = 2'd0;
        end else if (op == 0) begin
            st = model[addr];
            if (model[addr] == 2'd0) begin
                model[addr] = 2'd1; model_cnt++; st = 2'd1; er = 1'b0;
            end
        end else begin
            st = model[addr];
            if (model[addr] == 2'd0) begin
                model[addr] = 2'd2; st = 2'd2; er = 1'b0;
            end else if (model[addr] == 2'd1) begin
                model[addr] = 2'd3; model_cnt--; st = 2'd3; er = 1'b0;
            end
        end
    endtask

    // lat = clock edges after the accepting edge by which resp_valid is seen; hold = resp_valid one clock later.
    task automatic issue(input logic [1:0] op, input logic [7:0] addr, output int lat,
                         output logic [1:0] st, output logic er, output logic hold);
        int n;
        @(negedge clk);
        cmd_op = op; cmd_addr = addr; cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = -1;
        for (int k = 0; k < 8; k++) begin
            if (resp_valid === 1'b1) begin lat = k; break; end
            @(negedge clk);
        end
        st = resp_status;
        er = resp_err;
        @(negedge clk);
        hold = resp_valid;
    endtask

    task automatic read_cell(input logic [7:0] addr, output logic [1:0] v);
        @(negedge clk);
        rd_addr = addr;
        @(negedge clk);
        v = rd_data;
    endtask

    task automatic wait_clear(output int n, output logic rdy_seen);
        n = 0;
        rdy_seen = 1'b0;
        while (busy === 1'b1 && n < 400) begin
            if (cmd_ready !== 1'b0) rdy_seen = 1'b1;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic sweep_bad(output int nbad, output int first_bad);
        logic [7:0] a;
        nbad = 0;
        first_bad = -1;
        @(negedge clk);
        rd_addr = 8'd0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (rd_data !== 2'd0) begin
                nbad++;
                if (first_bad < 0) first_bad = i;
            end
            a = 8'(i + 1);
            rd_addr = a;
        end
    endtask

    task automatic test_reset();
        int n, nbad, fb;
        logic rdy;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (rd_data !== 2'd0) begin errors++; $display("FAIL rst_rd_data: got %0d expected 0", rd_data); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %0d expected 0", cmd_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %0d expected 0", resp_valid); end
        checks++; if (resp_status !== 2'd0) begin errors++; $display("FAIL rst_resp_status: got %0d expected 0", resp_status); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err: got %0d expected 0", resp_err); end
        checks++; if (ship_cnt !== 9'd0) begin errors++; $display("FAIL rst_ship_cnt: got %0d expected 0", ship_cnt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %0d expected 1", busy); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_clear(n, rdy);
        checks++; if (n !== 256) begin errors++; $display("FAIL rst_sweep_len: got %0d expected 256", n); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rst_ready_in_clear: got %0d expected 0", rdy); end
        sweep_bad(nbad, fb);
        checks++; if (nbad !== 0) begin errors++; $display("FAIL rst_cells_zero: got %0d nonzero (first %0d) expected 0", nbad, fb); end
        model_clear();
    endtask

    task automatic test_place();
        int lat; logic [1:0] st, ms, v; logic er, me, hold;
        model_cmd(0, 8'h23, ms, me);
        issue(2'd0, 8'h23, lat, st, er, hold);
        checks++; if (lat !== 2) begin errors++; $display("FAIL place_latency: got %0d expected 2", lat); end
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL place_pulse_width: got %0d expected 0", hold); end
        checks++; if (st !== 2'd1 || er !== 1'b0) begin errors++; $display("FAIL place_resp: got st=%0d err=%0d expected st=1 err=0", st, er); end
        checks++; if (ship_cnt !== 9'd1) begin errors++; $display("FAIL place_cnt: got %0d expected 1", ship_cnt); end
        read_cell(8'h23, v);
        checks++; if (v !== 2'd1) begin errors++; $display("FAIL place_read: got %0d expected 1", v); end
        model_cmd(0, 8'h23, ms, me);
        issue(2'd0, 8'h23, lat, st, er, hold);
        checks++; if (st !== 2'd1 || er !== 1'b1) begin errors++; $display("FAIL place_again: got st=%0d err=%0d expected st=1 err=1", st, er); end
        checks++; if (ship_cnt !== 9'd1) begin errors++; $display("FAIL place_again_cnt: got %0d expected 1", ship_cnt); end
    endtask

    task automatic test_shoot();
        int lat; logic [1:0] st, ms, v; logic er, me, hold;
        model_cmd(1, 8'h23, ms, me);
        issue(2'd1, 8'h23, lat, st, er, hold);
        checks++; if (st !== 2'd3 || er !== 1'b0) begin errors++; $display("FAIL shoot_hit: got st=%0d err=%0d expected st=3 err=0", st, er); end
        checks++; if (ship_cnt !== 9'd0) begin errors++; $display("FAIL shoot_hit_cnt: got %0d expected 0", ship_cnt); end
        model_cmd(1, 8'h23, ms, me);
        issue(2'd1, 8'h23, lat, st, er, hold);
        checks++; if (st !== 2'd3 || er !== 1'b1) begin errors++; $display("FAIL shoot_again: got st=%0d err=%0d expected st=3 err=1", st, er); end
        model_cmd(1, 8'h45, ms, me);
        issue(2'd1, 8'h45, lat, st, er, hold);
        checks++; if (st !== 2'd2 || er !== 1'b0) begin errors++; $display("FAIL shoot_miss: got st=%0d err=%0d expected st=2 err=0", st, er); end
        read_cell(8'h45, v);
        checks++; if (v !== 2'd2) begin errors++; $display("FAIL shoot_miss_read: got %0d expected 2", v); end
    endtask

    task automatic test_errors();
        int lat; logic [1:0] st, ms, v; logic er, me, hold;
        int cnt0;
        cnt0 = model_cnt;
        model_cmd(0, 8'hC0, ms, me);
        issue(2'd0, 8'hC0, lat, st, er, hold);
        checks++; if (st !== 2'd0 || er !== 1'b1) begin errors++; $display("FAIL offgrid_col: got st=%0d err=%0d expected st=0 err=1", st, er); end
        model_cmd(0, 8'h0A, ms, me);
        issue(2'd0, 8'h0A, lat, st, er, hold);
        checks++; if (st !== 2'd0 || er !== 1'b1) begin errors++; $display("FAIL offgrid_row: got st=%0d err=%0d expected st=0 err=1", st, er); end
        model_cmd(3, 8'h11, ms, me);
        issue(2'd3, 8'h11, lat, st, er, hold);
        checks++; if (st !== 2'd0 || er !== 1'b1) begin errors++; $display("FAIL reserved_op: got st=%0d err=%0d expected st=0 err=1", st, er); end
        checks++; if (ship_cnt !== 9'(cnt0)) begin errors++; $display("FAIL err_cnt: got %0d expected %0d", ship_cnt, cnt0); end
        read_cell(8'hC0, v);
        checks++; if (v !== 2'd0) begin errors++; $display("FAIL offgrid_cell: got %0d expected 0", v); end
        read_cell(8'h11, v);
        checks++; if (v !== 2'd0) begin errors++; $display("FAIL reserved_cell: got %0d expected 0", v); end
    endtask

    // Display read of a cell in the same cycle port B writes it.
    task automatic test_rw_collision();
        int n; logic [1:0] ms, v0, v1; logic me, rv;
        model_cmd(1, 8'h56, ms, me);
        @(negedge clk);
        cmd_op = 2'd1; cmd_addr = 8'h56; cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rd_addr = 8'h56;
        @(negedge clk);
        v0 = rd_data;
        rv = resp_valid;
        @(negedge clk);
        v1 = rd_data;
        checks++; if (rv !== 1'b1) begin errors++; $display("FAIL collide_resp: got %0d expected 1", rv); end
        checks++; if (v0 !== 2'd0) begin errors++; $display("FAIL collide_old: got %0d expected 0", v0); end
        checks++; if (v1 !== 2'd2) begin errors++; $display("FAIL collide_new: got %0d expected 2", v1); end
    endtask

    task automatic test_back_to_back();
        int n; logic [1:0] ms1, ms2; logic me1, me2, rdy_at_resp;
        model_cmd(0, 8'h77, ms1, me1);
        model_cmd(1, 8'h77, ms2, me2);
        @(negedge clk);
        cmd_op = 2'd0; cmd_addr = 8'h77; cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        cmd_op = 2'd1;
        n = 0;
        while (resp_valid !== 1'b1 && n < 8) begin @(negedge clk); n++; end
        rdy_at_resp = cmd_ready;
        checks++; if (resp_status !== ms1 || resp_err !== me1) begin errors++; $display("FAIL b2b_first: got st=%0d err=%0d expected st=%0d err=%0d", resp_status, resp_err, ms1, me1); end
        checks++; if (rdy_at_resp !== 1'b1) begin errors++; $display("FAIL b2b_ready_with_resp: got %0d expected 1", rdy_at_resp); end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (resp_valid !== 1'b1 && n < 8) begin @(negedge clk); n++; end
        checks++; if (n !== 2 || resp_status !== ms2 || resp_err !== me2) begin errors++; $display("FAIL b2b_second: got wait=%0d st=%0d err=%0d expected wait=2 st=%0d err=%0d", n, resp_status, resp_err, ms2, me2); end
        checks++; if (ship_cnt !== 9'(model_cnt)) begin errors++; $display("FAIL b2b_cnt: got %0d expected %0d", ship_cnt, model_cnt); end
    endtask

    task automatic test_random();
        int lat, r, op, addr; logic [1:0] st, ms, v; logic er, me, hold;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 8);
            op = (r < 4) ? 0 : (r < 8) ? 1 : 3;
            addr = $urandom_range(0, 10) * 16 + $urandom_range(0, 3);
            model_cmd(op, addr, ms, me);
            issue(2'(op), 8'(addr), lat, st, er, hold);
            checks++; if (lat !== 2 || st !== ms || er !== me) begin errors++; $display("FAIL rand_resp[%0d]: op=%0d addr=%h got lat=%0d st=%0d err=%0d expected lat=2 st=%0d err=%0d", i, op, addr, lat, st, er, ms, me); end
            checks++; if (ship_cnt !== 9'(model_cnt)) begin errors++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", i, ship_cnt, model_cnt); end
        end
        for (int i = 0; i < 12; i++) begin
            addr = $urandom_range(0, 10) * 16 + $urandom_range(0, 3);
            read_cell(8'(addr), v);
            checks++; if (v !== model[addr]) begin errors++; $display("FAIL rand_read[%h]: got %0d expected %0d", addr, v, model[addr]); end
        end
    endtask

    task automatic test_clear();
        int lat, n, nbad, fb, p0; logic [1:0] st, ms; logic er, me, hold, rdy;
        logic [7:0] cells [5];
        cells = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h99};
        for (int i = 0; i < 5; i++) begin
            model_cmd(0, cells[i], ms, me);
            issue(2'd0, cells[i], lat, st, er, hold);
        end
        checks++; if (ship_cnt !== 9'(model_cnt)) begin errors++; $display("FAIL clear_pre_cnt: got %0d expected %0d", ship_cnt, model_cnt); end
        p0 = resp_pulses;
        @(negedge clk);
        cmd_op = 2'd2; cmd_addr = 8'h00; cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_clear(n, rdy);
        checks++; if (n !== 256) begin errors++; $display("FAIL clear_sweep_len: got %0d expected 256", n); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL clear_ready_in_clear: got %0d expected 0", rdy); end
        checks++; if (resp_pulses !== p0) begin errors++; $display("FAIL clear_no_resp: got %0d pulses expected 0", resp_pulses - p0); end
        checks++; if (ship_cnt !== 9'd0) begin errors++; $display("FAIL clear_cnt: got %0d expected 0", ship_cnt); end
        sweep_bad(nbad, fb);
        checks++; if (nbad !== 0) begin errors++; $display("FAIL clear_cells_zero: got %0d nonzero (first %0d) expected 0", nbad, fb); end
        model_clear();
    endtask

    task automatic test_reset_midop();
        int n, p0; logic [1:0] v; logic rdy;
        p0 = resp_pulses;
        @(negedge clk);
        cmd_op = 2'd0; cmd_addr = 8'h33; cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_clear(n, rdy);
        checks++; if (n !== 256) begin errors++; $display("FAIL midrst_sweep_len: got %0d expected 256", n); end
        checks++; if (resp_pulses !== p0) begin errors++; $display("FAIL midrst_no_resp: got %0d pulses expected 0", resp_pulses - p0); end
        read_cell(8'h33, v);
        checks++; if (v !== 2'd0) begin errors++; $display("FAIL midrst_cell: got %0d expected 0", v); end
        checks++; if (ship_cnt !== 9'd0) begin errors++; $display("FAIL midrst_cnt: got %0d expected 0", ship_cnt); end
        model_clear();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_place();
        test_shoot();
        test_errors();
        test_rw_collision();
        test_back_to_back();
        test_random();
        test_clear();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
